scoreboard_counting: RTL and testbench

Register-dependency scoreboard for the vanilla core that tracks a per-register count of outstanding writes instead of a single busy bit, so multiple in-flight long-latency writes (remote loads, FP divide, FMA) to the same register can be tracked at once. It accepts several score and clear ports per cycle and reports RAW and, optionally, WAW hazards to the ID stage stall logic. It is a parametrised successor of the single-bit scoreboard and sits in the same place between decode and the writeback/clear paths.

---
 rtl/scoreboard_counting_pkg.sv | 20 ++
 rtl/scoreboard_counting_counter_entry.sv | 55 +++++
 rtl/scoreboard_counting.sv | 127 ++++++++++++
 tb/tb_scoreboard_counting.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/scoreboard_counting_pkg.sv
// Shared types and constants for the counting register scoreboard.
// Optional feature macro: SCOREBOARD_CLEAR_BYPASS_EN (consumed by scoreboard_counting).
package scoreboard_counting_pkg;

  // Default per-register counter width (max outstanding writes = 2^w - 1).
  localparam int unsigned scoreboard_count_width_gp = 2;
  localparam int unsigned reg_id_width_gp           = 5;

  // One score or clear port: strobe plus register id.
  typedef struct packed {
    logic                       v;
    logic [reg_id_width_gp-1:0] id;
  } sb_port_s;

  // Saturation value of a counter of the given width.
  function automatic int unsigned max_count(input int unsigned width);
    return (32'd1 << width) - 32'd1;
  endfunction

endpackage

// File: rtl/scoreboard_counting_counter_entry.sv
// One register's outstanding-write counter: applies net inc/dec, saturates at
// max on overflow, holds at zero on underflow, and flags both conditions.
module scoreboard_counting_counter_entry
  import scoreboard_counting_pkg::*;
#(
  parameter int unsigned count_width_p = scoreboard_count_width_gp,
  parameter int unsigned inc_width_p   = 2
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic [inc_width_p-1:0]   inc_i,
  input  logic [inc_width_p-1:0]   dec_i,
  output logic [count_width_p-1:0] count_o,
  output logic                     pending_o,
  output logic                     overflow_o,
  output logic                     underflow_o
);

  // Two guard bits: one for headroom above max, one for sign.
  localparam int unsigned SumW =
    ((count_width_p > inc_width_p) ? count_width_p : inc_width_p) + 2;
  localparam int unsigned MaxCount = max_count(count_width_p);

  logic [count_width_p-1:0] count_d, count_q;
  logic signed [SumW-1:0]   sum;
  logic                     over, under;

  // Net delta, range check, then saturate or hold.
  always_comb begin
    sum   = $signed(SumW'(count_q)) + $signed(SumW'(inc_i)) - $signed(SumW'(dec_i));
    over  = sum > $signed(SumW'(MaxCount));
    under = sum < $signed(SumW'(0));
    count_d = sum[count_width_p-1:0];
    if (over) begin
      count_d = count_width_p'(MaxCount);
    end else if (under) begin
      count_d = '0;
    end
  end

  // Counter state.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o     = count_q;
  assign pending_o   = (count_q != '0);
  assign overflow_o  = over;
  assign underflow_o = under;

endmodule

// File: rtl/scoreboard_counting.sv
// Counting register-dependency scoreboard: per-register outstanding-write
// counters with multi-port score/clear, RAW/WAW stall request and sticky error.
// Optional feature macro: SCOREBOARD_CLEAR_BYPASS_EN -- same-cycle clears
// release dependent instructions in the clear cycle.
module scoreboard_counting
  import scoreboard_counting_pkg::*;
#(
  parameter int unsigned els_p             = 32,
  parameter int unsigned num_src_port_p    = 3,
  parameter int unsigned num_score_port_p  = 2,
  parameter int unsigned num_clear_port_p  = 2,
  parameter int unsigned count_width_p     = scoreboard_count_width_gp,
  parameter bit          allow_waw_p       = 1'b1,
  parameter bit          x0_tied_to_zero_p = 1'b0,
  localparam int unsigned id_width_lp      = $clog2(els_p)
) (
  input  logic                                  clk_i,
  input  logic                                  reset_n_i,
  input  logic [num_src_port_p*id_width_lp-1:0] src_id_i,
  input  logic [num_src_port_p-1:0]             op_reads_rf_i,
  input  logic [id_width_lp-1:0]                dest_id_i,
  input  logic                                  op_writes_rf_i,
  input  logic [num_score_port_p-1:0]           score_i,
  input  logic [num_score_port_p*id_width_lp-1:0] score_id_i,
  input  logic [num_clear_port_p-1:0]           clear_i,
  input  logic [num_clear_port_p*id_width_lp-1:0] clear_id_i,
  output logic                                  dependency_o,
  output logic [els_p-1:0]                      pending_o,
  output logic                                  busy_o,
  output logic                                  error_o
);

  localparam int unsigned MaxPorts =
    (num_score_port_p > num_clear_port_p) ? num_score_port_p : num_clear_port_p;
  localparam int unsigned IncW     = $clog2(MaxPorts + 1);
  localparam int unsigned SumW     = ((count_width_p > IncW) ? count_width_p : IncW) + 2;
  localparam int unsigned MaxCount = max_count(count_width_p);

  logic [IncW-1:0]          inc_cnt [els_p];
  logic [IncW-1:0]          dec_cnt [els_p];
  logic [count_width_p-1:0] count   [els_p];
  logic signed [SumW-1:0]   eff_cnt [els_p];
  logic [els_p-1:0]         overflow, underflow;
  logic                     dep;
  logic                     error_d, error_q;

  // Decode score/clear ports into per-register hit counts; id 0 optionally ignored.
  always_comb begin
    for (int e = 0; e < int'(els_p); e++) begin
      inc_cnt[e] = '0;
      dec_cnt[e] = '0;
      for (int p = 0; p < int'(num_score_port_p); p++) begin
        if (score_i[p] && (score_id_i[p*id_width_lp +: id_width_lp] == id_width_lp'(e))
            && !(x0_tied_to_zero_p && (e == 0))) begin
          inc_cnt[e] = inc_cnt[e] + IncW'(1);
        end
      end
      for (int p = 0; p < int'(num_clear_port_p); p++) begin
        if (clear_i[p] && (clear_id_i[p*id_width_lp +: id_width_lp] == id_width_lp'(e))
            && !(x0_tied_to_zero_p && (e == 0))) begin
          dec_cnt[e] = dec_cnt[e] + IncW'(1);
        end
      end
    end
  end

  for (genvar e = 0; e < int'(els_p); e++) begin : g_entry
    scoreboard_counting_counter_entry #(
      .count_width_p (count_width_p),
      .inc_width_p   (IncW)
    ) u_entry (
      .clk_i       (clk_i),
      .reset_n_i   (reset_n_i),
      .inc_i       (inc_cnt[e]),
      .dec_i       (dec_cnt[e]),
      .count_o     (count[e]),
      .pending_o   (pending_o[e]),
      .overflow_o  (overflow[e]),
      .underflow_o (underflow[e])
    );
  end

  // Effective count seen by the stall logic: registered count plus same-cycle scores.
  always_comb begin
    for (int e = 0; e < int'(els_p); e++) begin
      eff_cnt[e] = $signed(SumW'(count[e])) + $signed(SumW'(inc_cnt[e]));
`ifdef SCOREBOARD_CLEAR_BYPASS_EN
      eff_cnt[e] = eff_cnt[e] - $signed(SumW'(dec_cnt[e]));
`endif
    end
  end

  // RAW on any valid source port, WAW on the destination.
  always_comb begin
    dep = 1'b0;
    for (int i = 0; i < int'(num_src_port_p); i++) begin
      if (op_reads_rf_i[i] &&
          (eff_cnt[src_id_i[i*id_width_lp +: id_width_lp]] > $signed(SumW'(0)))) begin
        dep = 1'b1;
      end
    end
    if (op_writes_rf_i) begin
      if (allow_waw_p) begin
        // Another write can only be tracked while the counter has room.
        if (eff_cnt[dest_id_i] >= $signed(SumW'(MaxCount))) dep = 1'b1;
      end else begin
        if (eff_cnt[dest_id_i] > $signed(SumW'(0))) dep = 1'b1;
      end
    end
  end

  assign error_d = error_q | (|overflow) | (|underflow);

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      error_q <= 1'b0;
    end else begin
      error_q <= error_d;
    end
  end

  assign dependency_o = dep;
  assign busy_o       = |pending_o;
  assign error_o      = error_q;

endmodule

// File: tb/tb_scoreboard_counting.sv
// Directed table-driven bench for scoreboard_counting, plus hand-written
// sequences for reset, underflow and the x0-tied-to-zero variant.
module tb_scoreboard_counting;

`ifdef SCOREBOARD_CLEAR_BYPASS_EN
  localparam bit Bypass = 1'b1;
`else
  localparam bit Bypass = 1'b0;
`endif

  logic        clk;
  logic        reset_n;
  logic [14:0] src_id;
  logic [2:0]  op_reads_rf;
  logic [4:0]  dest_id;
  logic        op_writes_rf;
  logic [1:0]  score;
  logic [9:0]  score_id;
  logic [1:0]  clear;
  logic [9:0]  clear_id;

  logic        dep, busy, err;
  logic [31:0] pend;
  logic        dep_x0, busy_x0, err_x0;
  logic [31:0] pend_x0;

  int n_checks = 0;
  int n_pass   = 0;

  scoreboard_counting dut (
    .clk_i          (clk),
    .reset_n_i      (reset_n),
    .src_id_i       (src_id),
    .op_reads_rf_i  (op_reads_rf),
    .dest_id_i      (dest_id),
    .op_writes_rf_i (op_writes_rf),
    .score_i        (score),
    .score_id_i     (score_id),
    .clear_i        (clear),
    .clear_id_i     (clear_id),
    .dependency_o   (dep),
    .pending_o      (pend),
    .busy_o         (busy),
    .error_o        (err)
  );

  scoreboard_counting #(
    .x0_tied_to_zero_p (1'b1)
  ) dut_x0 (
    .clk_i          (clk),
    .reset_n_i      (reset_n),
    .src_id_i       (src_id),
    .op_reads_rf_i  (op_reads_rf),
    .dest_id_i      (dest_id),
    .op_writes_rf_i (op_writes_rf),
    .score_i        (score),
    .score_id_i     (score_id),
    .clear_i        (clear),
    .clear_id_i     (clear_id),
    .dependency_o   (dep_x0),
    .pending_o      (pend_x0),
    .busy_o         (busy_x0),
    .error_o        (err_x0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  sc;
    logic [4:0]  sid0, sid1;
    logic [1:0]  cl;
    logic [4:0]  cid0, cid1;
    logic [2:0]  rd;
    logic [4:0]  s0, s1, s2;
    logic        wr;
    logic [4:0]  dst;
    logic        dep_nb;  // expected dependency without clear bypass
    logic        dep_b;   // expected dependency with clear bypass
    logic [31:0] pend;    // expected pending before this cycle's strobes land
    logic        err;
  } vec_t;

  vec_t vecs [17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic drive(input logic [1:0] sc, input logic [4:0] sid0, input logic [4:0] sid1,
                       input logic [1:0] cl, input logic [4:0] cid0, input logic [4:0] cid1,
                       input logic [2:0] rd, input logic [4:0] s0, input logic [4:0] s1,
                       input logic [4:0] s2, input logic wr, input logic [4:0] dst);
    score        = sc;
    score_id     = {sid1, sid0};
    clear        = cl;
    clear_id     = {cid1, cid0};
    op_reads_rf  = rd;
    src_id       = {s2, s1, s0};
    op_writes_rf = wr;
    dest_id      = dst;
  endtask

  task automatic idle();
    drive(2'b00, 5'd0, 5'd0, 2'b00, 5'd0, 5'd0, 3'b000, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0);
  endtask

  initial begin
    //          sc     sid0  sid1  cl     cid0  cid1  rd      s0    s1    s2    wr    dst   nb    b     pend          err
    vecs[0]  = '{2'b00, 5'd0, 5'd0, 2'b00, 5'd0, 5'd0, 3'b000, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0,        1'b0};
    vecs[1]  = '{2'b01, 5'd5, 5'd0, 2'b00, 5'd0, 5'd0, 3'b001, 5'd5, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 32'h0,        1'b0};
    vecs[2]  = '{2'b00, 5'd0, 5'd0, 2'b00, 5'd0, 5'd0, 3'b001, 5'd5, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 32'h20,       1'b0};
    vecs[3]  = '{2'b11, 5'd7, 5'd7, 2'b00, 5'd0, 5'd0, 3'b000, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h20,       1'b0};
    vecs[4]  = '{2'b00, 5'd0, 5'd0, 2'b01, 5'd7, 5'd0, 3'b001, 5'd7, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 32'hA0,       1'b0};
    vecs[5]  = '{2'b00, 5'd0, 5'd0, 2'b10, 5'd0, 5'd7, 3'b010, 5'd0, 5'd7, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 32'hA0,       1'b0};
    vecs[6]  = '{2'b00, 5'd0, 5'd0, 2'b00, 5'd0, 5'd0, 3'b001, 5'd7, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h20,       1'b0};
    vecs[7]  = '{2'b10, 5'd0, 5'd5, 2'b01, 5'd5, 5'd0, 3'b100, 5'd0, 5'd0, 5'd5, 1'b0, 5'd0, 1'b1, 1'b1, 32'h20,       1'b0};
    vecs[8]  = '{2'b11, 5'd9, 5'd9, 2'b00, 5'd0, 5'd0, 3'b000, 5'd0, 5'd0, 5'd0, 1'b1, 5'd9, 1'b0, 1'b0, 32'h20,       1'b0};
    vecs[9]  = '{2'b00, 5'd0, 5'd0, 2'b00, 5'd0, 5'd0, 3'b000, 5'd0, 5'd0, 5'd0, 1'b1, 5'd9, 1'b0, 1'b0, 32'h220,      1'b0};
    vecs[10] = '{2'b01, 5'd9, 5'd0, 2'b00, 5'd0, 5'd0, 3'b000, 5'd0, 5'd0, 5'd0, 1'b1, 5'd9, 1'b1, 1'b1, 32'h220,      1'b0};
    vecs[11] = '{2'b00, 5'd0, 5'd0, 2'b00, 5'd0, 5'd0, 3'b000, 5'd0, 5'd0, 5'd0, 1'b1, 5'd9, 1'b1, 1'b1, 32'h220,      1'b0};
    vecs[12] = '{2'b10, 5'd0, 5'd9, 2'b00, 5'd0, 5'd0, 3'b000, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h220,      1'b0};
    vecs[13] = '{2'b00, 5'd0, 5'd0, 2'b00, 5'd0, 5'd0, 3'b000, 5'd0, 5'd0, 5'd0, 1'b1, 5'd9, 1'b1, 1'b1, 32'h220,      1'b1};
    vecs[14] = '{2'b00, 5'd0, 5'd0, 2'b11, 5'd9, 5'd9, 3'b000, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h220,      1'b1};
    vecs[15] = '{2'b00, 5'd0, 5'd0, 2'b01, 5'd9, 5'd0, 3'b001, 5'd9, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 32'h220,      1'b1};
    vecs[16] = '{2'b00, 5'd0, 5'd0, 2'b00, 5'd0, 5'd0, 3'b001, 5'd9, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h20,       1'b1};

    // Reset state, and dependency from same-cycle scores while in reset.
    reset_n = 1'b0;
    idle();
    @(negedge clk);
    #1;
    check("reset_pending", pend, 32'h0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_error", {31'd0, err}, 32'd0);
    check("reset_dep_idle", {31'd0, dep}, 32'd0);
    drive(2'b01, 5'd5, 5'd0, 2'b00, 5'd0, 5'd0, 3'b001, 5'd5, 5'd0, 5'd0, 1'b0, 5'd0);
    #1;
    check("reset_dep_same_cycle_score", {31'd0, dep}, 32'd1);
    @(negedge clk);
    idle();
    #1;
    check("reset_holds_counts", pend, 32'h0);
    reset_n = 1'b1;

    // Table: drive at negedge, check combinational dependency and prior state.
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      drive(vecs[i].sc, vecs[i].sid0, vecs[i].sid1, vecs[i].cl, vecs[i].cid0, vecs[i].cid1,
            vecs[i].rd, vecs[i].s0, vecs[i].s1, vecs[i].s2, vecs[i].wr, vecs[i].dst);
      #1;
      check($sformatf("v%0d_dep", i), {31'd0, dep},
            {31'd0, (Bypass ? vecs[i].dep_b : vecs[i].dep_nb)});
      check($sformatf("v%0d_pending", i), pend, vecs[i].pend);
      check($sformatf("v%0d_busy", i), {31'd0, busy}, {31'd0, (vecs[i].pend != 32'h0)});
      check($sformatf("v%0d_error", i), {31'd0, err}, {31'd0, vecs[i].err});
    end

    // Asynchronous reset mid-cycle discards id 5's outstanding write and the error.
    @(negedge clk);
    drive(2'b00, 5'd0, 5'd0, 2'b00, 5'd0, 5'd0, 3'b001, 5'd5, 5'd0, 5'd0, 1'b0, 5'd0);
    #1;
    check("pre_reset_dep", {31'd0, dep}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_reset_pending", pend, 32'h0);
    check("mid_reset_busy", {31'd0, busy}, 32'd0);
    check("mid_reset_error", {31'd0, err}, 32'd0);
    check("mid_reset_dep", {31'd0, dep}, 32'd0);

    // Clear of a zero counter: sticky error, counter stays at zero.
    @(negedge clk);
    reset_n = 1'b1;
    drive(2'b00, 5'd0, 5'd0, 2'b01, 5'd4, 5'd0, 3'b000, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0);
    #1;
    check("underflow_err_before", {31'd0, err}, 32'd0);
    @(negedge clk);
    idle();
    #1;
    check("underflow_err_set", {31'd0, err}, 32'd1);
    check("underflow_pending", pend, 32'h0);
    drive(2'b01, 5'd4, 5'd0, 2'b00, 5'd0, 5'd0, 3'b000, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0);
    @(negedge clk);
    idle();
    #1;
    check("underflow_held_zero", pend, 32'h10);
    check("underflow_err_sticky", {31'd0, err}, 32'd1);

    // Register 0 tracked normally by the default build, ignored by the x0 variant.
    reset_n = 1'b0;
    #1;
    reset_n = 1'b1;
    drive(2'b01, 5'd0, 5'd0, 2'b00, 5'd0, 5'd0, 3'b001, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0);
    #1;
    check("x0_main_dep", {31'd0, dep}, 32'd1);
    check("x0_tied_dep", {31'd0, dep_x0}, 32'd0);
    @(negedge clk);
    idle();
    #1;
    check("x0_main_pending", pend, 32'h1);
    check("x0_tied_pending", pend_x0, 32'h0);
    check("x0_tied_busy", {31'd0, busy_x0}, 32'd0);
    drive(2'b00, 5'd0, 5'd0, 2'b01, 5'd0, 5'd0, 3'b000, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0);
    @(negedge clk);
    @(negedge clk);
    idle();
    #1;
    check("x0_main_err", {31'd0, err}, 32'd1);
    check("x0_tied_err", {31'd0, err_x0}, 32'd0);
    check("x0_main_pending_cleared", pend, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
